wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage plus architectural integer register file of the 5-stage RV32I pipeline.
- Consumes the MEM/WB pipeline register outputs and selects write-back data (ALU result or load data).
- Commits the selected value to x1..x31 and serves the two ID-stage read ports with same-cycle write-through bypass.
- Exports the write-back value, destination and enable for the EX-stage forwarding unit.

Parameters:
- XLEN, 32, data width of registers and datapath.
- NREG, 32, number of architectural registers; index width = clog2(NREG) = 5.
- RST_CLEAR, 1, 1 = synchronous reset clears all registers to 0; 0 = reset only blocks writes and leaves contents.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- RegWrite_i  in  1  write-back enable from MEM/WB
- MemtoReg_i  in  1  1 = write load data, 0 = write ALU result
- addr_i  in  XLEN  ALU result / memory address from MEM/WB
- Read_data_i  in  XLEN  load data from MEM/WB
- rd_i  in  5  destination register index from MEM/WB
- RS1addr_i  in  5  ID-stage read port 1 index
- RS2addr_i  in  5  ID-stage read port 2 index
- RS1data_o  out  XLEN  read port 1 data (combinational)
- RS2data_o  out  XLEN  read port 2 data (combinational)
- wb_data_o  out  XLEN  selected write-back value (combinational)
- wb_rd_o  out  5  write-back destination (= rd_i)
- wb_en_o  out  1  effective write enable = RegWrite_i & (rd_i != 0) & ~rst_i
- wb_count_o  out  32  count of committed register writes

Behaviour:
- Write-back mux: wb_data_o = MemtoReg_i ? Read_data_i : addr_i. The mux is pure combinational and needs no clock.
- Commit: on posedge clk_i, if wb_en_o is 1, then reg[rd_i] <= wb_data_o. Write latency is 1 edge.
- x0: never written and always reads 0. A write with rd_i = 0 is dropped and does not increment wb_count_o.
- Read ports: asynchronous array read.
  - Bypass: if wb_en_o is 1 and RSnaddr_i == rd_i, then RSndata_o = wb_data_o in the same cycle. The write-first result is visible to ID without waiting for the edge.
  - If RSnaddr_i == 0, RSndata_o = 0, regardless of any bypass.
  - Both ports may hit the same register or the bypass at once; each resolves independently.
- wb_count_o:
  - Increments by 1 on each edge where wb_en_o = 1.
  - Wraps 0xFFFFFFFF -> 0 without flagging.
- Reset (rst_i = 1 at a posedge):
  - If RST_CLEAR = 1, all registers become 0.
  - wb_count_o becomes 0.
  - Any write presented in that cycle is discarded. Reset wins over a simultaneous write.
  - While rst_i = 1, wb_en_o = 0, so there is no bypass. Read ports return the array contents, which are 0 after the first reset edge when RST_CLEAR = 1.
- Reset mid-operation: a write pending in the reset cycle is lost. The first write after rst_i deasserts commits normally on the next edge.
- Output reset values:
  - After a reset edge, RSndata_o = 0 (RST_CLEAR = 1) and wb_count_o = 0.
  - wb_data_o, wb_rd_o and wb_en_o are combinational from their inputs; wb_en_o is forced 0 while rst_i = 1.
- Unknown/X on RegWrite_i while rst_i = 0 is a bench error; no RTL protection.

Decomposition:
- Shared package (pipeline pkg): XLEN, NREG, REG_IDX_W = 5, and the constant X0 = 5'd0.
- Define a wb_src enum in that package: WB_ALU = 0, WB_MEM = 1. MemtoReg_i is compared against it.
- One sub-module, regfile_2r1w: storage array, x0 masking, write-first bypass, reset clear.
- The top level holds the write-back mux, the wb_en_o qualification and the commit counter.

Test Plan:
- Reset clear: fill x1..x31 with 0xA5A5_0000+i, assert rst_i for 1 edge -> all 31 reads return 0, wb_count_o = 0.
- ALU write then read: RegWrite_i=1, MemtoReg_i=0, addr_i=0x0000_1234, rd_i=5, one edge; then RS1addr_i=5 -> RS1data_o = 0x0000_1234, wb_count_o = 1.
- Load write with bypass: RegWrite_i=1, MemtoReg_i=1, Read_data_i=0xDEAD_BEEF, rd_i=7, RS1addr_i=RS2addr_i=7 in the same cycle -> both read ports show 0xDEAD_BEEF before the edge, and x7 holds it after.
- x0 protection: RegWrite_i=1, rd_i=0, addr_i=0xFFFF_FFFF -> wb_en_o=0, RS1addr_i=0 reads 0, wb_count_o unchanged.
- Reset vs write collision: rst_i=1 with RegWrite_i=1, rd_i=3, addr_i=0x55 -> after the edge x3 = 0 and wb_count_o = 0. The next edge with the same write gives x3 = 0x55 and wb_count_o = 1.
- Counter wrap: force wb_count_o to 0xFFFF_FFFF via a sequence or backdoor, do one valid write -> wb_count_o = 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants and the write-back source encoding used by the
// write-back stage and its register file.
package wb_regfile_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] X0 = 5'd0;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// Architectural integer register file: two asynchronous read ports with
// write-first bypass, one synchronous write port, x0 hard-wired to zero.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int XLEN      = wb_regfile_pkg::XLEN,
    parameter int NREG      = wb_regfile_pkg::NREG,
    parameter int RST_CLEAR = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [REG_IDX_W-1:0] waddr_i,
    input  logic [XLEN-1:0]      wdata_i,
    input  logic [REG_IDX_W-1:0] raddr1_i,
    input  logic [REG_IDX_W-1:0] raddr2_i,
    output logic [XLEN-1:0]      rdata1_o,
    output logic [XLEN-1:0]      rdata2_o
);

    logic [XLEN-1:0] regs_q [NREG];

    // Reset beats a simultaneous write; without RST_CLEAR it only blocks it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (RST_CLEAR != 0) begin
                for (int i = 0; i < NREG; i++) begin
                    regs_q[i] <= '0;
                end
            end
        end else if (we_i && (waddr_i != X0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = '0;
        if (raddr1_i != X0) begin
            if (we_i && (raddr1_i == waddr_i)) begin
                rdata1_o = wdata_i;
            end else begin
                rdata1_o = regs_q[raddr1_i];
            end
        end
    end

    always_comb begin
        rdata2_o = '0;
        if (raddr2_i != X0) begin
            if (we_i && (raddr2_i == waddr_i)) begin
                rdata2_o = wdata_i;
            end else begin
                rdata2_o = regs_q[raddr2_i];
            end
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage of the RV32I pipeline: selects ALU or load data, qualifies
// the commit, counts committed writes and hosts the register file.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN      = wb_regfile_pkg::XLEN,
    parameter int NREG      = wb_regfile_pkg::NREG,
    parameter int RST_CLEAR = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 RegWrite_i,
    input  logic                 MemtoReg_i,
    input  logic [XLEN-1:0]      addr_i,
    input  logic [XLEN-1:0]      Read_data_i,
    input  logic [REG_IDX_W-1:0] rd_i,
    input  logic [REG_IDX_W-1:0] RS1addr_i,
    input  logic [REG_IDX_W-1:0] RS2addr_i,
    output logic [XLEN-1:0]      RS1data_o,
    output logic [XLEN-1:0]      RS2data_o,
    output logic [XLEN-1:0]      wb_data_o,
    output logic [REG_IDX_W-1:0] wb_rd_o,
    output logic                 wb_en_o,
    output logic [31:0]          wb_count_o
);

    logic [31:0] wbCount_q;
    logic [31:0] wbCount_d;

    assign wb_data_o = (MemtoReg_i == logic'(WB_MEM)) ? Read_data_i : addr_i;
    assign wb_rd_o   = rd_i;
    assign wb_en_o   = RegWrite_i & (rd_i != X0) & ~rst_i;

    // The counter wraps silently; only effective commits are counted.
    always_comb begin
        wbCount_d = wbCount_q;
        if (wb_en_o) begin
            wbCount_d = wbCount_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbCount_q <= '0;
        end else begin
            wbCount_q <= wbCount_d;
        end
    end

    assign wb_count_o = wbCount_q;

    regfile_2r1w #(
        .XLEN      (XLEN),
        .NREG      (NREG),
        .RST_CLEAR (RST_CLEAR)
    ) u_regfile (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (wb_en_o),
        .waddr_i  (rd_i),
        .wdata_i  (wb_data_o),
        .raddr1_i (RS1addr_i),
        .raddr2_i (RS2addr_i),
        .rdata1_o (RS1data_o),
        .rdata2_o (RS2data_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset clear, ALU/load commits,
// same-cycle bypass, x0 protection, reset/write collision and counter wrap.
module tb_wb_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i;
    logic        MemtoReg_i;
    logic [31:0] addr_i;
    logic [31:0] Read_data_i;
    logic [4:0]  rd_i;
    logic [4:0]  RS1addr_i;
    logic [4:0]  RS2addr_i;
    logic [31:0] RS1data_o;
    logic [31:0] RS2data_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_en_o;
    logic [31:0] wb_count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    wb_regfile #(
        .XLEN      (32),
        .NREG      (32),
        .RST_CLEAR (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .RegWrite_i  (RegWrite_i),
        .MemtoReg_i  (MemtoReg_i),
        .addr_i      (addr_i),
        .Read_data_i (Read_data_i),
        .rd_i        (rd_i),
        .RS1addr_i   (RS1addr_i),
        .RS2addr_i   (RS2addr_i),
        .RS1data_o   (RS1data_o),
        .RS2data_o   (RS2data_o),
        .wb_data_o   (wb_data_o),
        .wb_rd_o     (wb_rd_o),
        .wb_en_o     (wb_en_o),
        .wb_count_o  (wb_count_o)
    );

    task automatic applyStimulus(input logic rst, input logic we, input logic m2r,
                                 input logic [31:0] alu, input logic [31:0] ld,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2);
        rst_i       = rst;
        RegWrite_i  = we;
        MemtoReg_i  = m2r;
        addr_i      = alu;
        Read_data_i = ld;
        rd_i        = rd;
        RS1addr_i   = rs1;
        RS2addr_i   = rs2;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inputs change just after a falling edge, so one rising edge commits them.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        checkOutput("reset_count", wb_count_o, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 5'd4, 5'd4, 5'd0);
        checkOutput("reset_blocks_en", {31'd0, wb_en_o}, 32'd0);
        checkOutput("reset_no_bypass", RS1data_o, 32'd0);

        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'hA5A5_0000 + i, 32'h0, 5'(i), 5'd0, 5'd0);
            step();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd31);
        checkOutput("fill_x1", RS1data_o, 32'hA5A5_0001);
        checkOutput("fill_x31", RS2data_o, 32'hA5A5_001F);
        checkOutput("fill_count", wb_count_o, 32'd31);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(32 - i));
            checkOutput($sformatf("clear_rs1_x%0d", i), RS1data_o, 32'd0);
            checkOutput($sformatf("clear_rs2_x%0d", 32 - i), RS2data_o, 32'd0);
        end
        checkOutput("clear_count", wb_count_o, 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'hCAFE_0000, 5'd5, 5'd0, 5'd0);
        checkOutput("alu_wb_data", wb_data_o, 32'h0000_1234);
        checkOutput("alu_wb_rd", {27'd0, wb_rd_o}, 32'd5);
        checkOutput("alu_wb_en", {31'd0, wb_en_o}, 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        checkOutput("alu_read_x5", RS1data_o, 32'h0000_1234);
        checkOutput("alu_count", wb_count_o, 32'd1);

        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_1111, 32'hDEAD_BEEF, 5'd7, 5'd7, 5'd7);
        checkOutput("ld_wb_data", wb_data_o, 32'hDEAD_BEEF);
        checkOutput("ld_bypass_rs1", RS1data_o, 32'hDEAD_BEEF);
        checkOutput("ld_bypass_rs2", RS2data_o, 32'hDEAD_BEEF);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd5);
        checkOutput("ld_read_x7", RS1data_o, 32'hDEAD_BEEF);
        checkOutput("ld_read_x5", RS2data_o, 32'h0000_1234);
        checkOutput("ld_count", wb_count_o, 32'd2);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_wb_en", {31'd0, wb_en_o}, 32'd0);
        checkOutput("x0_wb_data", wb_data_o, 32'hFFFF_FFFF);
        checkOutput("x0_read", RS1data_o, 32'd0);
        step();
        checkOutput("x0_read_after", RS2data_o, 32'd0);
        checkOutput("x0_count", wb_count_o, 32'd2);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0055, 32'h0, 5'd3, 5'd3, 5'd0);
        checkOutput("coll_wb_en", {31'd0, wb_en_o}, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd5);
        checkOutput("coll_x3", RS1data_o, 32'd0);
        checkOutput("coll_x5_cleared", RS2data_o, 32'd0);
        checkOutput("coll_count", wb_count_o, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0055, 32'h0, 5'd3, 5'd3, 5'd7);
        checkOutput("retry_bypass", RS1data_o, 32'h0000_0055);
        checkOutput("retry_other_port", RS2data_o, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        checkOutput("retry_x3", RS1data_o, 32'h0000_0055);
        checkOutput("retry_count", wb_count_o, 32'd1);

        dut.wbCount_q = 32'hFFFF_FFFF;
        #1;
        checkOutput("wrap_preload", wb_count_o, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h1357_9BDF, 5'd9, 5'd0, 5'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd3);
        checkOutput("wrap_count", wb_count_o, 32'd0);
        checkOutput("wrap_x9", RS1data_o, 32'h1357_9BDF);
        checkOutput("wrap_x3", RS2data_o, 32'h0000_0055);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
